// File: rtl/iic_slave_if.sv
// Local-side handshake between the I2C target and the register/data logic it serves.
// The bus pins (SCL, open-drain SDA) stay plain ports on the target itself.
`timescale 1ns/1ps
interface iic_slave_if;
    logic       rx_ack_en;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       rw;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       nack_det;

    modport slave (
        input  rx_ack_en, tx_data,
        output rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det, nack_det
    );

    modport master (
        output rx_ack_en, tx_data,
        input  rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det, nack_det
    );
endinterface

// File: rtl/iic_slave.sv
// I2C target: filtered SCL/SDA sampling, START/STOP detection, 7-bit address match,
// byte-wise write delivery and read fetch with open-drain SDA and tHD;DAT output hold.
`timescale 1ns/1ps
module iic_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    inout  wire        io_sda,
    iic_slave_if.slave bus
);

    localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    logic [1:0]    r_scl_sync, r_sda_sync;
    logic [FW-1:0] r_scl_cnt, r_sda_cnt;
    logic          r_scl_f, r_sda_f, r_scl_d, r_sda_d;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic          r_byte_done, w_byte_done_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_tx_shift, w_tx_shift_nxt;
    logic [7:0]    r_rx_data, w_rx_data_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_rx_valid, w_rx_valid_nxt;
    logic          r_tx_req, w_tx_req_nxt;
    logic          r_start_det, w_start_det_nxt;
    logic          r_stop_det, w_stop_det_nxt;
    logic          r_nack_det, w_nack_det_nxt;

    logic          r_sda_oe, r_oe_pend;
    logic [HW-1:0] r_hold_cnt;
    logic          w_oe_load, w_oe_val, w_oe_clear;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_f & ~r_scl_d;
    assign w_scl_fall = ~r_scl_f & r_scl_d;
    assign w_start    = r_scl_f & r_sda_d & ~r_sda_f;
    assign w_stop     = r_scl_f & ~r_sda_d & r_sda_f;

    // Input synchronizer, stability filter and one-cycle delayed copies for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_cnt  <= {FW{1'b0}};
            r_sda_cnt  <= {FW{1'b0}};
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], io_sda};
            r_scl_d    <= r_scl_f;
            r_sda_d    <= r_sda_f;
            if (r_scl_sync[1] == r_scl_f) begin
                r_scl_cnt <= {FW{1'b0}};
            end else if (r_scl_cnt == FW'(FILT_LEN - 1)) begin
                r_scl_f   <= r_scl_sync[1];
                r_scl_cnt <= {FW{1'b0}};
            end else begin
                r_scl_cnt <= r_scl_cnt + {{(FW-1){1'b0}}, 1'b1};
            end
            if (r_sda_sync[1] == r_sda_f) begin
                r_sda_cnt <= {FW{1'b0}};
            end else if (r_sda_cnt == FW'(FILT_LEN - 1)) begin
                r_sda_f   <= r_sda_sync[1];
                r_sda_cnt <= {FW{1'b0}};
            end else begin
                r_sda_cnt <= r_sda_cnt + {{(FW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and next-output logic; START/STOP take priority over any bit activity
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_done_nxt = r_byte_done;
        w_shift_nxt     = r_shift;
        w_tx_shift_nxt  = r_tx_shift;
        w_rx_data_nxt   = r_rx_data;
        w_rw_nxt        = r_rw;
        w_busy_nxt      = r_busy;
        w_rx_valid_nxt  = 1'b0;
        w_tx_req_nxt    = 1'b0;
        w_start_det_nxt = 1'b0;
        w_stop_det_nxt  = 1'b0;
        w_nack_det_nxt  = 1'b0;
        w_oe_load       = 1'b0;
        w_oe_val        = 1'b0;
        w_oe_clear      = 1'b0;

        if (w_stop) begin
            w_state_nxt     = S_IDLE;
            w_busy_nxt      = 1'b0;
            w_stop_det_nxt  = 1'b1;
            w_oe_clear      = 1'b1;
            w_bit_cnt_nxt   = 3'd7;
            w_byte_done_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt     = S_ADDR;
            w_start_det_nxt = 1'b1;
            w_oe_clear      = 1'b1;
            w_bit_cnt_nxt   = 3'd7;
            w_byte_done_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], r_sda_f};
                        if (r_bit_cnt == 3'd0) begin
                            w_byte_done_nxt = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done_nxt = 1'b0;
                        w_bit_cnt_nxt   = 3'd7;
                        w_oe_load       = 1'b1;
                        if (r_state == S_WR_DATA) begin
                            w_rx_data_nxt  = r_shift;
                            w_rx_valid_nxt = 1'b1;
                            w_oe_val       = bus.rx_ack_en;
                            w_state_nxt    = S_WR_ACK;
                        end else if ((r_shift[7:1] == DEV_ADDR) && (r_shift[7:1] != 7'h00)) begin
                            w_rw_nxt     = r_shift[0];
                            w_busy_nxt   = 1'b1;
                            w_tx_req_nxt = r_shift[0];
                            w_oe_val     = 1'b1;
                            w_state_nxt  = S_ADDR_ACK;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_oe_val    = 1'b0;
                            w_state_nxt = S_IGNORE;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_ADDR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_load     = 1'b1;
                        w_bit_cnt_nxt = 3'd7;
                        if ((r_state == S_ADDR_ACK) && r_rw) begin
                            w_tx_shift_nxt = bus.tx_data;
                            w_oe_val       = ~bus.tx_data[7];
                            w_state_nxt    = S_RD_DATA;
                        end else begin
                            w_oe_val    = 1'b0;
                            w_state_nxt = S_WR_DATA;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise) begin
                        if (r_bit_cnt == 3'd0) begin
                            w_byte_done_nxt = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                        end
                    end else if (w_scl_fall) begin
                        w_oe_load = 1'b1;
                        if (r_byte_done) begin
                            w_byte_done_nxt = 1'b0;
                            w_bit_cnt_nxt   = 3'd7;
                            w_oe_val        = 1'b0;
                            w_state_nxt     = S_RD_ACK;
                        end else begin
                            w_oe_val       = ~r_tx_shift[6];
                            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
                        end
                    end else begin
                        w_state_nxt = S_RD_DATA;
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (r_sda_f) begin
                            w_nack_det_nxt = 1'b1;
                            w_busy_nxt     = 1'b0;
                            w_state_nxt    = S_IGNORE;
                        end else begin
                            w_tx_req_nxt = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        w_tx_shift_nxt = bus.tx_data;
                        w_oe_load      = 1'b1;
                        w_oe_val       = ~bus.tx_data[7];
                        w_bit_cnt_nxt  = 3'd7;
                        w_state_nxt    = S_RD_DATA;
                    end else begin
                        w_state_nxt = S_RD_ACK;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_oe_clear  = 1'b1;
                end
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd7;
            r_byte_done <= 1'b0;
            r_shift     <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_nack_det  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_byte_done <= w_byte_done_nxt;
            r_shift     <= w_shift_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rw        <= w_rw_nxt;
            r_busy      <= w_busy_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_req    <= w_tx_req_nxt;
            r_start_det <= w_start_det_nxt;
            r_stop_det  <= w_stop_det_nxt;
            r_nack_det  <= w_nack_det_nxt;
        end
    end

    // SDA drive: a new level is applied HOLD_CYC clocks after the SCL fall that scheduled it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_oe   <= 1'b0;
            r_oe_pend  <= 1'b0;
            r_hold_cnt <= {HW{1'b0}};
        end else if (w_oe_clear) begin
            r_sda_oe   <= 1'b0;
            r_oe_pend  <= 1'b0;
            r_hold_cnt <= {HW{1'b0}};
        end else if (w_oe_load) begin
            r_oe_pend  <= w_oe_val;
            r_hold_cnt <= HW'(HOLD_CYC);
        end else if (r_hold_cnt != {HW{1'b0}}) begin
            r_hold_cnt <= r_hold_cnt - {{(HW-1){1'b0}}, 1'b1};
            if (r_hold_cnt == {{(HW-1){1'b0}}, 1'b1}) begin
                r_sda_oe <= r_oe_pend;
            end
        end
    end

    assign io_sda        = r_sda_oe ? 1'b0 : 1'bz;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.tx_req    = r_tx_req;
    assign bus.rw        = r_rw;
    assign bus.busy      = r_busy;
    assign bus.start_det = r_start_det;
    assign bus.stop_det  = r_stop_det;
    assign bus.nack_det  = r_nack_det;

endmodule

// File: tb/tb_iic_slave.sv
// Bit-banged I2C master driving iic_slave; local-side pulses are checked against a
// queue of expected events, bus-level ACKs and read bytes are checked by the master.
`timescale 1ns/1ps
module tb_iic_slave;
    localparam time T = 200ns;  // quarter SCL period

    localparam logic [2:0] EV_START = 3'd0;
    localparam logic [2:0] EV_STOP  = 3'd1;
    localparam logic [2:0] EV_RXV   = 3'd2;
    localparam logic [2:0] EV_TXREQ = 3'd3;
    localparam logic [2:0] EV_NACK  = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;

    logic clk;
    logic rst_n;
    logic m_scl;
    logic m_sda_oe;
    wire  sda;

    int n_checks = 0;
    int n_fail   = 0;

    ev_t        exp_q[$];
    logic [7:0] tx_q[$];

    iic_slave_if bus_if ();

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup pu_sda (sda);

    iic_slave #(.DEV_ADDR(7'h50), .HOLD_CYC(4), .FILT_LEN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_scl (m_scl),
        .io_sda(sda),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [2:0] kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got event %0d data %h, expected none", kind, data);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", {5'd0, kind}, {5'd0, e.kind});
            if (kind == EV_RXV) chk("sb_rx_data", data, e.data);
        end
    endtask

    // Monitor: every local-side pulse consumes one expected event
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.start_det) sb_pop(EV_START, 8'h00);
                if (bus_if.stop_det)  sb_pop(EV_STOP, 8'h00);
                if (bus_if.rx_valid)  sb_pop(EV_RXV, bus_if.rx_data);
                if (bus_if.tx_req)    sb_pop(EV_TXREQ, 8'h00);
                if (bus_if.nack_det)  sb_pop(EV_NACK, 8'h00);
            end
        end
    end

    // Local-side responder: answer each tx_req with the next queued read byte
    initial begin
        bus_if.tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && bus_if.tx_req && (tx_q.size() > 0)) bus_if.tx_data = tx_q.pop_front();
        end
    end

    task automatic bit_cycle(input logic drive_low, output logic sampled);
        m_sda_oe = drive_low;
        #T m_scl = 1'b1;
        #T sampled = sda;
        #T m_scl = 1'b0;
        #T;
    endtask

    task automatic i2c_start();
        m_sda_oe = 1'b1;
        #T m_scl = 1'b0;
        #T;
    endtask

    task automatic i2c_rstart();
        m_sda_oe = 1'b0;
        #T m_scl = 1'b1;
        #T m_sda_oe = 1'b1;
        #T m_scl = 1'b0;
        #T;
    endtask

    task automatic i2c_stop();
        m_sda_oe = 1'b1;
        #T m_scl = 1'b1;
        #T m_sda_oe = 1'b0;
        #T;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(~d[i], s);
        bit_cycle(1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b0, s);
            d = {d[6:0], s};
        end
        bit_cycle(~nack, s);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] rd;

        rst_n = 1'b0;
        m_scl = 1'b1;
        m_sda_oe = 1'b0;
        bus_if.rx_ack_en = 1'b1;
        #100 rst_n = 1'b1;
        #T;
        chk("reset_sda", {7'd0, sda}, 8'h01);
        chk("reset_busy", {7'd0, bus_if.busy}, 8'h00);
        chk("reset_rw", {7'd0, bus_if.rw}, 8'h00);
        chk("reset_rx_data", bus_if.rx_data, 8'h00);

        // 1: write 0xA5, 0x3C
        expect_ev(EV_START, 8'h00);
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t1_addr_ack", {7'd0, ack}, 8'h00);
        chk("t1_busy", {7'd0, bus_if.busy}, 8'h01);
        expect_ev(EV_RXV, 8'hA5);
        send_byte(8'hA5, ack);
        chk("t1_d0_ack", {7'd0, ack}, 8'h00);
        expect_ev(EV_RXV, 8'h3C);
        send_byte(8'h3C, ack);
        chk("t1_d1_ack", {7'd0, ack}, 8'h00);
        chk("t1_rw", {7'd0, bus_if.rw}, 8'h00);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();
        chk("t1_busy_end", {7'd0, bus_if.busy}, 8'h00);

        // 2: read 0x81 (ACK), 0x7E (NACK)
        tx_q.push_back(8'h81);
        tx_q.push_back(8'h7E);
        expect_ev(EV_START, 8'h00);
        expect_ev(EV_TXREQ, 8'h00);
        i2c_start();
        send_byte(8'hA1, ack);
        chk("t2_addr_ack", {7'd0, ack}, 8'h00);
        chk("t2_rw", {7'd0, bus_if.rw}, 8'h01);
        expect_ev(EV_TXREQ, 8'h00);
        read_byte(1'b0, rd);
        chk("t2_rd0", rd, 8'h81);
        expect_ev(EV_NACK, 8'h00);
        read_byte(1'b1, rd);
        chk("t2_rd1", rd, 8'h7E);
        chk("t2_busy", {7'd0, bus_if.busy}, 8'h00);
        chk("t2_sda_rel", {7'd0, sda}, 8'h01);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();

        // 3: wrong address 0x51
        expect_ev(EV_START, 8'h00);
        i2c_start();
        send_byte(8'hA2, ack);
        chk("t3_addr_nack", {7'd0, ack}, 8'h01);
        send_byte(8'h99, ack);
        chk("t3_data_nack", {7'd0, ack}, 8'h01);
        chk("t3_busy", {7'd0, bus_if.busy}, 8'h00);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();

        // 4: write 0x12, repeated START, read 0xC3
        tx_q.push_back(8'hC3);
        expect_ev(EV_START, 8'h00);
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t4_addr_ack", {7'd0, ack}, 8'h00);
        expect_ev(EV_RXV, 8'h12);
        send_byte(8'h12, ack);
        chk("t4_d0_ack", {7'd0, ack}, 8'h00);
        expect_ev(EV_START, 8'h00);
        expect_ev(EV_TXREQ, 8'h00);
        i2c_rstart();
        send_byte(8'hA1, ack);
        chk("t4_raddr_ack", {7'd0, ack}, 8'h00);
        chk("t4_rw", {7'd0, bus_if.rw}, 8'h01);
        chk("t4_rx_data", bus_if.rx_data, 8'h12);
        expect_ev(EV_NACK, 8'h00);
        read_byte(1'b1, rd);
        chk("t4_rd0", rd, 8'hC3);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();

        // 5: data NACK with rx_ack_en low, byte still delivered
        bus_if.rx_ack_en = 1'b0;
        expect_ev(EV_START, 8'h00);
        i2c_start();
        send_byte(8'hA0, ack);
        chk("t5_addr_ack", {7'd0, ack}, 8'h00);
        expect_ev(EV_RXV, 8'h55);
        send_byte(8'h55, ack);
        chk("t5_data_nack", {7'd0, ack}, 8'h01);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();
        bus_if.rx_ack_en = 1'b1;
        chk("t5_rx_data", bus_if.rx_data, 8'h55);

        // 6: reset while the target holds SDA low in a read byte
        tx_q.push_back(8'h81);
        expect_ev(EV_START, 8'h00);
        expect_ev(EV_TXREQ, 8'h00);
        i2c_start();
        send_byte(8'hA1, ack);
        chk("t6_addr_ack", {7'd0, ack}, 8'h00);
        bit_cycle(1'b0, b);
        chk("t6_bit7", {7'd0, b}, 8'h01);
        chk("t6_sda_low", {7'd0, sda}, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("t6_sda_rel", {7'd0, sda}, 8'h01);
        chk("t6_busy", {7'd0, bus_if.busy}, 8'h00);
        chk("t6_rw", {7'd0, bus_if.rw}, 8'h00);
        chk("t6_rx_data", bus_if.rx_data, 8'h00);
        m_scl = 1'b1;
        #T rst_n = 1'b1;
        #T;

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL sb_missing: got nothing, expected event %0d data %h", e.kind, e.data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
